// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, reset PC default, fetch FSM encoding.
package cpu_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned IF_ID_BUS_W = 64;
   localparam int unsigned JBR_BUS_W   = 33;
   localparam int unsigned CNT_W       = 2;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP          = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_redirect.sv
// Holds the pending jump/branch target from decode and picks the next PC
// (same-cycle bypass, then pending target, then sequential).
module fetch_redirect
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 next_fetch,
   input  logic                 jbr_latch,
   input  logic [JBR_BUS_W-1:0] jbr_bus,
   input  logic [XLEN-1:0]      pc,
   output logic [XLEN-1:0]      next_pc_c
);

   logic            jbr_pend_q, jbr_pend_d;
   logic [XLEN-1:0] jbr_tgt_r_q, jbr_tgt_r_d;
   logic            taken_c;
   logic [XLEN-1:0] target_c;

   assign taken_c  = jbr_latch & jbr_bus[JBR_BUS_W-1];
   assign target_c = jbr_bus[XLEN-1:0];

   // Newest taken capture wins; every PC advance consumes the pending target.
   always_comb begin
      jbr_pend_d  = jbr_pend_q;
      jbr_tgt_r_d = jbr_tgt_r_q;
      if (taken_c) begin
         jbr_pend_d  = 1'b1;
         jbr_tgt_r_d = target_c;
      end
      if (next_fetch) begin
         jbr_pend_d = 1'b0;
      end
   end

   always_comb begin
      if (taken_c) begin
         next_pc_c = target_c;
      end else if (jbr_pend_q) begin
         next_pc_c = jbr_tgt_r_q;
      end else begin
         next_pc_c = pc + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         jbr_pend_q  <= 1'b0;
         jbr_tgt_r_q <= '0;
      end else begin
         jbr_pend_q  <= jbr_pend_d;
         jbr_tgt_r_q <= jbr_tgt_r_d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM latency wait, IF->ID bus.
// Optional FETCH_ALIGN_CHK_EN adds inst_addr_err and NOP substitution on misaligned PC.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
   parameter int unsigned ROM_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   IF_valid,
   input  logic                   next_fetch,
   input  logic                   jbr_latch,
   input  logic [JBR_BUS_W-1:0]   jbr_bus,
   output logic [XLEN-1:0]        inst_addr,
   input  logic [XLEN-1:0]        inst,
   output logic                   IF_over,
   output logic [IF_ID_BUS_W-1:0] IF_ID_bus,
   output logic [XLEN-1:0]        IF_pc,
   output logic [XLEN-1:0]        IF_inst
`ifdef FETCH_ALIGN_CHK_EN
   ,
   output logic                   inst_addr_err
`endif
);

   fetch_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  inst_r_q, inst_r_d;
   logic             if_over_q, if_over_d;
   logic [XLEN-1:0]  next_pc_c;
   logic [XLEN-1:0]  fetched_c;

   fetch_redirect u_redirect (
      .clk        (clk),
      .resetn     (resetn),
      .next_fetch (next_fetch),
      .jbr_latch  (jbr_latch),
      .jbr_bus    (jbr_bus),
      .pc         (pc_q),
      .next_pc_c  (next_pc_c)
   );

`ifdef FETCH_ALIGN_CHK_EN
   logic err_q, err_d;
   assign fetched_c     = (pc_q[1:0] != 2'b00) ? NOP : inst;
   assign err_d         = (pc_d[1:0] != 2'b00) && (state_d != IDLE);
   assign inst_addr_err = err_q;
`else
   assign fetched_c = inst;
`endif

   // PC advance overrides everything and discards any fetch in flight.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_d      = pc_q;
      inst_r_d  = inst_r_q;
      if_over_d = 1'b0;
      if (next_fetch) begin
         pc_d    = next_pc_c;
         state_d = IDLE;
         cnt_d   = '0;
      end else if (!IF_valid) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = WAIT;
               cnt_d   = CNT_W'(ROM_LATENCY - 1);
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  inst_r_d = fetched_c;
                  state_d  = DONE;
               end
            end
            DONE:    if_over_d = 1'b1;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pc_q      <= RESET_PC;
         inst_r_q  <= '0;
         if_over_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pc_q      <= pc_d;
         inst_r_q  <= inst_r_d;
         if_over_q <= if_over_d;
`ifdef FETCH_ALIGN_CHK_EN
         err_q     <= err_d;
`endif
      end
   end

   assign inst_addr = pc_q;
   assign IF_pc     = pc_q;
   assign IF_inst   = inst_r_q;
   assign IF_over   = if_over_q;
   assign IF_ID_bus = {pc_q, inst_r_q};

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: two instances (latency 1 and latency 3).
module tb_fetch_stage;

   logic        clk;
   logic        resetn, rstn3;
   logic        if_valid, next_fetch, jbr_latch;
   logic [32:0] jbr_bus;
   logic [31:0] inst_addr, inst, if_pc, if_inst;
   logic        if_over;
   logic [63:0] if_id_bus;
   logic        if_valid3, next_fetch3;
   logic [31:0] inst_addr3, inst3, if_pc3, if_inst3;
   logic        if_over3;
   logic [63:0] if_id_bus3;
`ifdef FETCH_ALIGN_CHK_EN
   logic        inst_addr_err, inst_addr_err3;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      int          start;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   logic over_prev = 1'b0;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a == 32'h0) ? 32'h2408_0005 : (a ^ 32'hDEAD_0000);
   endfunction

   assign inst  = rom(inst_addr);
   assign inst3 = rom(inst_addr3);

   fetch_stage #(.RESET_PC(32'h0000_0000), .ROM_LATENCY(1)) u_dut (
      .clk(clk), .resetn(resetn), .IF_valid(if_valid), .next_fetch(next_fetch),
      .jbr_latch(jbr_latch), .jbr_bus(jbr_bus), .inst_addr(inst_addr), .inst(inst),
      .IF_over(if_over), .IF_ID_bus(if_id_bus), .IF_pc(if_pc), .IF_inst(if_inst)
`ifdef FETCH_ALIGN_CHK_EN
      , .inst_addr_err(inst_addr_err)
`endif
   );

   fetch_stage #(.RESET_PC(32'h0000_1000), .ROM_LATENCY(3)) u_dut3 (
      .clk(clk), .resetn(rstn3), .IF_valid(if_valid3), .next_fetch(next_fetch3),
      .jbr_latch(1'b0), .jbr_bus(33'h0), .inst_addr(inst_addr3), .inst(inst3),
      .IF_over(if_over3), .IF_ID_bus(if_id_bus3), .IF_pc(if_pc3), .IF_inst(if_inst3)
`ifdef FETCH_ALIGN_CHK_EN
      , .inst_addr_err(inst_addr_err3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cmp64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every rising IF_over must match the oldest expected fetch.
   always @(posedge clk) begin
      #2;
      if (if_over && !over_prev) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_if_over: IF_ID_bus=%h with no fetch pending", if_id_bus);
         end else begin
            mon_e = sb_q.pop_front();
            cmp64("if_id_bus", if_id_bus, {mon_e.pc, mon_e.inst});
            cmp32("if_over_latency", 32'(cyc - mon_e.start), 32'd3);
            cmp32("if_pc", if_pc, mon_e.pc);
            cmp32("if_inst", if_inst, mon_e.inst);
         end
      end
      over_prev = if_over;
   end

   task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] exp_inst);
      exp_t e;
      e.pc = exp_pc;
      e.inst = exp_inst;
      e.start = cyc;
      sb_q.push_back(e);
      if_valid = 1'b1;
      for (int i = 0; i < 10 && !if_over; i++) tick();
      if (!if_over) begin
         n_vec++;
         n_err++;
         $display("FAIL fetch_timeout: IF_over=%b expected 1 at pc %h", if_over, exp_pc);
      end
   endtask

   task automatic advance(input logic byp, input logic [31:0] tgt);
      jbr_latch  = byp;
      jbr_bus    = {byp, tgt};
      next_fetch = 1'b1;
      tick();
      next_fetch = 1'b0;
      jbr_latch  = 1'b0;
      jbr_bus    = '0;
      if_valid   = 1'b0;
   endtask

   task automatic jbr(input logic taken, input logic [31:0] tgt);
      jbr_latch = 1'b1;
      jbr_bus   = {taken, tgt};
      tick();
      jbr_latch = 1'b0;
      jbr_bus   = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded bound", $time);
      $fatal(1);
   end

   initial begin
      logic stuck;
      int   j;
      resetn = 1'b0; rstn3 = 1'b0;
      if_valid = 1'b0; next_fetch = 1'b0; jbr_latch = 1'b0; jbr_bus = '0;
      if_valid3 = 1'b0; next_fetch3 = 1'b0;
      tick(); tick();
      cmp32("reset_inst_addr", inst_addr, 32'h0);
      cmp64("reset_if_id_bus", if_id_bus, 64'h0);
      cmp32("reset_if_over", {31'h0, if_over}, 32'h0);
      cmp32("reset_inst_addr3", inst_addr3, 32'h0000_1000);
      resetn = 1'b1; rstn3 = 1'b1;
      tick();

      // Basic fetch and sequential advance
      fetch(32'h0, 32'h2408_0005);
      advance(1'b0, 32'h0);
      cmp32("adv_pc_4", inst_addr, 32'h4);
      cmp32("adv_if_over_drop", {31'h0, if_over}, 32'h0);
      advance(1'b0, 32'h0);
      advance(1'b0, 32'h0);
      advance(1'b0, 32'h0);
      cmp32("adv_pc_10", inst_addr, 32'h10);
      fetch(32'h10, 32'hDEAD_0010);
      advance(1'b0, 32'h0);
      cmp32("adv_pc_14", inst_addr, 32'h14);
      cmp32("adv14_if_over_drop", {31'h0, if_over}, 32'h0);

      // Pending redirect captured three cycles early; not-taken ignored
      jbr(1'b1, 32'h100);
      jbr(1'b0, 32'h500);
      tick();
      advance(1'b0, 32'h0);
      cmp32("pend_redirect", inst_addr, 32'h100);
      advance(1'b0, 32'h0);
      cmp32("pend_cleared", inst_addr, 32'h104);

      // Same-edge bypass beats an older pending target
      jbr(1'b1, 32'h300);
      jbr(1'b1, 32'h100);
      tick();
      advance(1'b1, 32'h200);
      cmp32("bypass_redirect", inst_addr, 32'h200);
      advance(1'b0, 32'h0);
      cmp32("bypass_pend_cleared", inst_addr, 32'h204);

      // Later capture overwrites earlier
      jbr(1'b1, 32'h300);
      jbr(1'b1, 32'h180);
      advance(1'b0, 32'h0);
      cmp32("overwrite_redirect", inst_addr, 32'h180);

      // Wrap at top of address space
      advance(1'b1, 32'hFFFF_FFFC);
      cmp32("redir_top", inst_addr, 32'hFFFF_FFFC);
      fetch(32'hFFFF_FFFC, 32'h2152_FFFC);
      advance(1'b0, 32'h0);
      cmp32("wrap_pc", inst_addr, 32'h0);

      // next_fetch mid-WAIT discards the fetch
      if_valid = 1'b1;
      tick();
      advance(1'b0, 32'h0);
      cmp32("discard_pc", inst_addr, 32'h4);
      stuck = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         stuck |= if_over;
      end
      cmp32("discard_no_if_over", {31'h0, stuck}, 32'h0);
      fetch(32'h4, 32'hDEAD_0004);

      // Misaligned target passes through unmodified
      advance(1'b1, 32'h102);
      cmp32("misaligned_pc", inst_addr, 32'h102);
`ifdef FETCH_ALIGN_CHK_EN
      fetch(32'h102, 32'h0);
      cmp32("addr_err_set", {31'h0, inst_addr_err}, 32'h1);
      advance(1'b0, 32'h0);
      cmp32("addr_err_idle", {31'h0, inst_addr_err}, 32'h0);
`else
      fetch(32'h102, 32'hDEAD_0102);
      advance(1'b0, 32'h0);
`endif
      cmp32("misaligned_seq", inst_addr, 32'h106);
      tick(); tick();

      // Latency-3 instance: abort, then async reset mid-WAIT
      next_fetch3 = 1'b1;
      tick();
      next_fetch3 = 1'b0;
      cmp32("l3_adv", inst_addr3, 32'h1004);
      if_valid3 = 1'b1;
      tick(); tick();
      if_valid3 = 1'b0;
      tick();
      cmp32("l3_abort_no_over", {31'h0, if_over3}, 32'h0);
      if_valid3 = 1'b1;
      tick();
      #3 rstn3 = 1'b0;
      #1;
      cmp32("l3_async_reset_pc", inst_addr3, 32'h1000);
      cmp32("l3_reset_no_over", {31'h0, if_over3}, 32'h0);
      if_valid3 = 1'b0;
      tick();
      rstn3 = 1'b1;
      stuck = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         stuck |= if_over3;
      end
      cmp32("l3_never_over", {31'h0, stuck}, 32'h0);
      if_valid3 = 1'b1;
      j = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (if_over3) begin
            j = i;
            break;
         end
      end
      cmp32("l3_latency", 32'(j), 32'd5);
      cmp64("l3_if_id_bus", if_id_bus3, {32'h0000_1000, 32'hDEAD_1000});
      if_valid3 = 1'b0;
      tick();

      cmp32("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
